// File: rtl/mem_responder_if.sv
// Request/response bundle between the two core memory initiators (fetch
// and load/store) and the memory responder.
// Optional: MEM_ADDR_CHECK_EN adds the per-port error pulses if_err/d_err.
`timescale 1ns/1ps

interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Instruction-fetch read port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

`ifdef MEM_ADDR_CHECK_EN
    logic              if_err;
    logic              d_err;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err
    );
`else
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Single-clock memory responder shared by the fetch and load/store ports.
// Arbitrates (alternating on ties), waits WAIT_CYCLES, performs one array
// access, then pulses the granted port's rvalid one cycle later.
// Optional: MEM_ADDR_CHECK_EN adds if_err/d_err pulses for out-of-range accesses.
`timescale 1ns/1ps

module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk1,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    typedef enum logic {FETCH, DATA} src_t;

    localparam logic [2:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_next;
    src_t                last_served, cur_src;
    logic [2:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                grant_if, grant_d, grant_any;
    logic                resp_pending;
    logic                in_range;
    logic [DATA_W-1:0]   read_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign grant_any    = grant_if | grant_d;
    assign resp_pending = if_rvalid_q | d_rvalid_q;
    assign in_range     = {1'b0, addr_q} < DEPTH_LIM;
    assign read_word    = in_range ? mem[addr_q] : '0;

    // State register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration and next-state; the response cycle blocks new grants so
    // rvalid and a grant never share a cycle.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (!resp_pending) begin
                    if (bus.d_req && (!bus.if_req || last_served == FETCH)) begin
                        grant_d = 1'b1;
                    end else if (bus.if_req) begin
                        grant_if = 1'b1;
                    end
                    if (grant_d || grant_if) begin
                        state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, wait counter and registered responses
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            last_served <= FETCH;
            cur_src     <= FETCH;
            cnt         <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (grant_any) begin
                cur_src     <= grant_d ? DATA : FETCH;
                last_served <= grant_d ? DATA : FETCH;
                addr_q      <= grant_d ? bus.d_addr : bus.if_addr;
                we_q        <= grant_d & bus.d_we;
                wdata_q     <= bus.d_wdata;
                cnt         <= WAIT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 3'd1;
            end
            if (state == ACCESS) begin
                if (cur_src == DATA) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= we_q ? '0 : read_word;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= read_word;
                end
            end
        end
    end

    // Array write; state is forced to IDLE by reset, so an aborted store never lands
    always_ff @(posedge clk1) begin
        if (state == ACCESS && cur_src == DATA && we_q && in_range) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic if_err_q, d_err_q;

    // Out-of-range flag, pulsed alongside the matching rvalid
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            if_err_q <= 1'b0;
            d_err_q  <= 1'b0;
        end else begin
            if_err_q <= (state == ACCESS) && (cur_src == FETCH) && !in_range;
            d_err_q  <= (state == ACCESS) && (cur_src == DATA)  && !in_range;
        end
    end

    assign bus.if_err = if_err_q;
    assign bus.d_err  = d_err_q;
`endif

    // Grants are combinational, so they are masked while reset is held
    assign bus.if_gnt    = grant_if & reset;
    assign bus.d_gnt     = grant_d & reset;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = reset & (grant_any | (state != IDLE) | resp_pending);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=1 and
// DEPTH=200, one with WAIT_CYCLES=0.
`timescale 1ns/1ps

module tb_mem_responder;
    logic clk1  = 1'b0;
    logic reset = 1'b0;
    logic busy, busy0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk1 = ~clk1;

    mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_CYCLES(1)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus0.slave),
        .busy  (busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk1);
        #1;
    endtask

    // Full transaction on the main instance; returns grant-to-rvalid latency
    // (-1 if no grant or no rvalid within the bound) and the returned data.
    task automatic acc(input bit use_d, input bit we, input logic [7:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        int g;
        g     = -1;
        lat   = -1;
        rdata = 32'hxxxxxxxx;
        if (use_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int i = 0; i < 12; i++) begin
            #1;
            if ((use_d ? bus.d_gnt : bus.if_gnt) === 1'b1) begin
                g = i;
                break;
            end
            @(posedge clk1);
            #1;
        end
        @(posedge clk1);
        #1;
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        if (g >= 0) begin
            for (int j = 1; j < 12; j++) begin
                #1;
                if ((use_d ? bus.d_rvalid : bus.if_rvalid) === 1'b1) begin
                    lat   = j;
                    rdata = use_d ? bus.d_rdata : bus.if_rdata;
                    break;
                end
                @(posedge clk1);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          ng;
        int          gc [8];
        bit          gd [8];
        int          cnt_ifg, cnt_ifv, cnt_dv;

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;

        // Reset state, with a request already pending
        adv(); adv();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h05; bus.d_wdata = 32'hDEADBEEF;
        #1;
        chk("rst_d_gnt",     bus.d_gnt,     0);
        chk("rst_if_gnt",    bus.if_gnt,    0);
        chk("rst_busy",      busy,          0);
        chk("rst_d_rvalid",  bus.d_rvalid,  0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_d_rdata",   bus.d_rdata,   0);
        chk("rst_if_rdata",  bus.if_rdata,  0);

        // Store DEADBEEF to 0x05 (grant N, ack N+3), then fetch it back
        reset = 1;
        #1;
        chk("st_gnt_N",      bus.d_gnt,  1);
        chk("st_if_gnt_N",   bus.if_gnt, 0);
        chk("st_busy_N",     busy,       1);
        adv(); bus.d_req = 0; #1;
        chk("st_gnt_N1",     bus.d_gnt,    0);
        chk("st_busy_N1",    busy,         1);
        chk("st_rvalid_N1",  bus.d_rvalid, 0);
        adv(); #1;
        chk("st_rvalid_N2",  bus.d_rvalid, 0);
        adv(); bus.if_req = 1; bus.if_addr = 8'h05; #1;
        chk("st_rvalid_N3",  bus.d_rvalid, 1);
        chk("st_rdata_N3",   bus.d_rdata,  0);
        chk("no_gnt_on_rv",  bus.if_gnt,   0);
        chk("st_busy_N3",    busy,         1);
        adv(); #1;
        chk("f_gnt",         bus.if_gnt,   1);
        chk("st_rvalid_N4",  bus.d_rvalid, 0);
        adv(); bus.if_req = 0; #1;
        chk("f_rvalid_1",    bus.if_rvalid, 0);
        adv(); #1;
        chk("f_rvalid_2",    bus.if_rvalid, 0);
        adv(); #1;
        chk("f_rvalid_3",    bus.if_rvalid, 1);
        chk("f_rdata",       bus.if_rdata,  32'hDEADBEEF);
        adv(); #1;
        chk("f_rvalid_off",  bus.if_rvalid, 0);
        chk("f_rdata_hold",  bus.if_rdata,  32'hDEADBEEF);
        chk("f_busy_off",    busy,          0);

        // Zero wait states: preload 0x10, then load it (rvalid at N+2)
        adv();
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 8'h10; bus0.d_wdata = 32'h12345678; #1;
        chk("w0_st_gnt",     bus0.d_gnt, 1);
        adv(); bus0.d_req = 0;
        adv(); #1;
        chk("w0_st_rvalid",  bus0.d_rvalid, 1);
        adv(); adv();
        bus0.d_req = 1; bus0.d_we = 0; #1;
        chk("w0_ld_gnt",     bus0.d_gnt, 1);
        chk("w0_busy_N",     busy0,      1);
        adv(); bus0.d_req = 0; #1;
        chk("w0_busy_N1",    busy0,         1);
        chk("w0_rvalid_N1",  bus0.d_rvalid, 0);
        adv(); #1;
        chk("w0_rvalid_N2",  bus0.d_rvalid, 1);
        chk("w0_rdata",      bus0.d_rdata,  32'h12345678);
        chk("w0_busy_N2",    busy0,         1);
        adv(); #1;
        chk("w0_busy_N3",    busy0,         0);
        chk("w0_rvalid_N3",  bus0.d_rvalid, 0);
        chk("w0_rdata_hold", bus0.d_rdata,  32'h12345678);

        // Both ports requesting continuously from reset: D,F,D,F every 4 cycles
        adv();
        reset = 0;
        bus.if_req = 1; bus.if_addr = 8'h05;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h05;
        adv(); adv();
        reset = 1;
        ng = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (bus.d_gnt === 1'b1 || bus.if_gnt === 1'b1) begin
                if (ng < 8) begin
                    gc[ng] = c;
                    gd[ng] = bus.d_gnt;
                end
                ng++;
            end
            adv();
        end
        bus.if_req = 0; bus.d_req = 0;
        chk("arb_count",  ng, 5);
        chk("arb_first",  gc[0], 0);
        chk("arb_g0_d",   gd[0], 1);
        chk("arb_g1_f",   gd[1], 0);
        chk("arb_g2_d",   gd[2], 1);
        chk("arb_g3_f",   gd[3], 0);
        for (int k = 0; k < 3; k++) chk("arb_gap", gc[k+1] - gc[k], 4);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (busy === 1'b0) break;
            adv();
        end
        chk("arb_idle", busy, 0);

        // Reset one cycle after a store grant aborts it
        adv();
        acc(1, 1, 8'h20, 32'hAAAAAAAA, rd, lat); adv();
        chk("pre_st_lat", lat, 3);
        acc(1, 0, 8'h05, 32'h0, rd, lat); adv();
        chk("pre_ld_data", rd, 32'hDEADBEEF);
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 32'h55555555; #1;
        chk("ab_gnt", bus.d_gnt, 1);
        adv(); reset = 0; bus.d_req = 0; #1;
        chk("ab_busy",    busy,          0);
        chk("ab_d_rdata", bus.d_rdata,   0);
        chk("ab_if_rdat", bus.if_rdata,  0);
        chk("ab_rvalid",  bus.d_rvalid,  0);
        adv(); #1;
        chk("ab_rvalid2", bus.d_rvalid,  0);
        adv(); reset = 1; #1;
        chk("ab_rvalid3", bus.d_rvalid,  0);
        adv();
        acc(1, 0, 8'h20, 32'h0, rd, lat); adv();
        chk("ab_mem_kept", rd, 32'hAAAAAAAA);
        chk("ab_ld_lat",   lat, 3);

        // Out-of-range (DEPTH=200) load/store to 0xF0
        acc(1, 0, 8'hF0, 32'h0, rd, lat);
        chk("oor_ld_lat",  lat, 3);
        chk("oor_ld_data", rd, 0);
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_ld_err",  bus.d_err, 1);
`endif
        adv();
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_err_off", bus.d_err, 0);
`endif
        acc(1, 1, 8'hF0, 32'h13572468, rd, lat); adv();
        chk("oor_st_lat",  lat, 3);
        acc(1, 0, 8'hF0, 32'h0, rd, lat); adv();
        chk("oor_ld2",     rd, 0);
        acc(0, 0, 8'h05, 32'h0, rd, lat);
        chk("oor_f_lat",   lat, 3);
        chk("oor_f_data",  rd, 32'hDEADBEEF);
`ifdef MEM_ADDR_CHECK_EN
        chk("inr_if_err",  bus.if_err, 0);
`endif
        adv();

        // Fetch request raised and dropped while a load is in service
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h20; #1;
        chk("drop_d_gnt", bus.d_gnt, 1);
        adv(); bus.d_req = 0; bus.if_req = 1; bus.if_addr = 8'h05; #1;
        chk("drop_if_gnt_wait", bus.if_gnt, 0);
        adv(); bus.if_req = 0;
        cnt_ifg = 0; cnt_ifv = 0; cnt_dv = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.if_gnt === 1'b1)    cnt_ifg++;
            if (bus.if_rvalid === 1'b1) cnt_ifv++;
            if (bus.d_rvalid === 1'b1)  cnt_dv++;
            adv();
        end
        chk("drop_if_gnts",   cnt_ifg, 0);
        chk("drop_if_rvalid", cnt_ifv, 0);
        chk("drop_d_rvalid",  cnt_dv,  1);
        chk("drop_d_rdata",   bus.d_rdata, 32'hAAAAAAAA);
        #1;
        chk("drop_idle",      busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-clock memory responder serving the pipelined core's two memory initiators: the instruction-fetch read port and the load/store data port.
- Holds a DEPTH x DATA_W word array.
- Arbitrates between the two request ports, then services one access at a time with a programmable wait-state count.
- Returns a one-cycle response pulse per accepted request.

Parameters:
ADDR_W, 8, word-address width of both request ports
DATA_W, 32, word width
DEPTH, 256, number of implemented words (1..2**ADDR_W)
WAIT_CYCLES, 1, extra cycles between grant and access (0..7)

Ports:
clk1  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request, level, held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request, level, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data (0 on store ack)
busy  out  1  high from grant through response cycle
if_err, d_err  out  1 each  present only with MEM_ADDR_CHECK_EN

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE; wait counter 0; last_served = FETCH.
  - Array contents are not reset.
  - Reset mid-access aborts it: no array write, no rvalid.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - If any request is asserted, grant one; if_gnt/d_gnt is high in this same cycle.
  - Capture addr, we, wdata and the granted source.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- Arbitration:
  - One requester only: it is granted.
  - Both requesting: grant the source not recorded in last_served. After reset, data wins the first tie.
  - last_served updates on every grant.
- WAIT: counter loads WAIT_CYCLES-1 at grant and decrements each cycle; at 0, go to ACCESS.
- ACCESS (one cycle):
  - Read: rdata = array[captured addr], registered.
  - Write: array[captured addr] <= captured wdata; d_rdata = 0.
  - The granted source's rvalid is high the following cycle, then return to IDLE.
- Latency: grant in cycle N gives rvalid in cycle N+2+WAIT_CYCLES.
- No new grant until the state is back in IDLE.
- Throughput: one access per 3+WAIT_CYCLES cycles.
- rdata holds its value after rvalid until the next response to the same port.
- Request inputs are sampled only in IDLE. Dropping a request before its grant is legal and produces no response.
- A grant and rvalid to different ports can never coincide. rvalid and a new grant never occur in the same cycle.
- Out-of-range address (addr >= DEPTH) without the macro:
  - Read returns 0.
  - Write is dropped.
  - rvalid is still pulsed.
- Store followed by a fetch to the same address returns the new data: the write completes before any later grant.

Optional Feature:
MEM_ADDR_CHECK_EN
- Defined:
  - Adds if_err and d_err.
  - Out-of-range accesses pulse err together with rvalid, return rdata 0 and perform no write.
  - err is 0 whenever rvalid is 0.
- Undefined: ports absent; out-of-range behaviour as in Behaviour.

Test Plan:
- Reset, then d_req=1, d_we=1, d_addr=0x05, d_wdata=0xDEADBEEF with WAIT_CYCLES=1 → d_gnt in cycle N, d_rvalid in N+3, d_rdata=0. Then if_req, if_addr=0x05 → if_rvalid with if_rdata=0xDEADBEEF.
- if_req and d_req both asserted continuously after reset → grants alternate D, F, D, F; no two grants closer than 4 cycles.
- WAIT_CYCLES=0, load from 0x10 preloaded with 0x12345678 → d_rvalid in N+2, d_rdata=0x12345678; busy high for cycles N..N+2.
- Assert reset one cycle after a store grant to 0x20 (old value 0xAAAAAAAA) → all outputs 0, no rvalid, array[0x20] still 0xAAAAAAAA.
- DEPTH=200, load from 0xF0 → d_rdata=0, d_rvalid pulses; with MEM_ADDR_CHECK_EN, d_err=1 in the same cycle. Store to 0xF0 → no array change.
- if_req raised then dropped before grant while data is being serviced → no if_gnt, no if_rvalid; arbiter returns to IDLE idle.
